lif_scheduler: RTL and testbench

LIF_SCHEDULER -- requirements
Module: lif_scheduler

---
 rtl/lif_pkg.sv | 31 +++
 rtl/lif_core.sv | 27 ++
 rtl/lif_scheduler.sv | 169 ++++++++++++++++
 tb/tb_lif_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lif_pkg
// Brief    : Shared types and constants for the LIF neuron scheduler. The
//            package provides the FSM state enum, the saturation width and
//            the default firing threshold. It also provides a saturating
//            8-bit adder used for both current accumulation and integration.
// Revision : 1.0 - initial release
// ============================================================================
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } lif_state_t;

  localparam int SAT_W = 8;
  localparam logic [SAT_W-1:0] SAT_MAX = '1;
  localparam int LIF_DEF_THRESHOLD = 32;

  // Unsigned add clamped to the largest SAT_W-bit value.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b);
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SAT_W] ? SAT_MAX : sum[SAT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lif_core.sv
`default_nettype none
// ============================================================================
// Module   : lif_core
// Brief    : Combinational leaky-integrate step for one neuron. It computes
//            next = sat(pending + state/2) and flags a spike when next
//            reaches the threshold. One instance is shared by all neurons.
// Revision : 1.0 - initial release
// ============================================================================
module lif_core
  import lif_pkg::*;
(
  input  logic [SAT_W-1:0] state_in,
  input  logic [SAT_W-1:0] pending_in,
  input  logic [SAT_W-1:0] threshold,
  output logic [SAT_W-1:0] next_out,
  output logic             spike
);

  // The leak halves the membrane before the pending current is added.
  logic [SAT_W-1:0] w_leak;

  assign w_leak   = state_in >> 1;
  assign next_out = sat_add(pending_in, w_leak);
  assign spike    = (next_out >= threshold);

endmodule
`default_nettype wire

// File: rtl/lif_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_scheduler
// Brief    : Time-multiplexed LIF neuron array. Stimuli accumulate into
//            per-neuron pending registers while idle. A tick launches a
//            sweep that integrates one neuron per cycle through a shared
//            lif_core. Results are registered one cycle after each
//            processing cycle.
//            Optional: define LIF_SCHED_REFRACTORY_EN to add a per-neuron
//            refractory counter that suppresses integration after a spike.
// Revision : 1.0 - initial release
// ============================================================================
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS     = 4,
  parameter int DEF_THRESHOLD = LIF_DEF_THRESHOLD,
  parameter int REFRACT_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(N_NEURONS)-1:0] in_idx,
  input  logic [SAT_W-1:0]             in_current,
  input  logic                         cfg_we,
  input  logic [SAT_W-1:0]             cfg_threshold,
  output logic                         spike_valid,
  output logic [$clog2(N_NEURONS)-1:0] spike_idx,
  output logic [SAT_W-1:0]             mem_out,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int IDX_W = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  lif_state_t       r_fsm;
  logic [IDX_W-1:0] r_idx;
  logic [SAT_W-1:0] r_threshold;
  logic [SAT_W-1:0] r_state   [N_NEURONS];
  logic [SAT_W-1:0] r_pending [N_NEURONS];

  logic             w_accept;
  logic             w_processing;
  logic             w_core_spike;
  logic             w_fire;
  logic [SAT_W-1:0] w_next;
  logic [SAT_W-1:0] w_mem;

  assign w_accept     = in_valid && in_ready;
  assign w_processing = (r_fsm == ST_SWEEP);

  lif_core u_core (
    .state_in   (r_state[r_idx]),
    .pending_in (r_pending[r_idx]),
    .threshold  (r_threshold),
    .next_out   (w_next),
    .spike      (w_core_spike)
  );

`ifdef LIF_SCHED_REFRACTORY_EN
  localparam int REFR_W = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;
  localparam logic [REFR_W-1:0] REFR_ONE = REFR_W'(1);

  logic [REFR_W-1:0] r_refr [N_NEURONS];
  logic              w_refractory;

  // A refractory neuron reports a zero membrane and never fires.
  assign w_refractory = (r_refr[r_idx] != '0);
  assign w_fire       = w_core_spike && !w_refractory;
  assign w_mem        = w_refractory ? '0 : w_next;

  // Load the counter on a spike and count it down once per visit in a sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_refr[i] <= '0;
      end
    end else if (w_processing) begin
      if (w_refractory) begin
        r_refr[r_idx] <= r_refr[r_idx] - REFR_ONE;
      end else if (w_core_spike) begin
        r_refr[r_idx] <= REFR_W'(REFRACT_TICKS);
      end
    end
  end
`else
  assign w_fire = w_core_spike;
  assign w_mem  = w_next;
`endif

  // Neuron memories: accumulate stimuli while idle, commit integration in a sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_state[i]   <= '0;
        r_pending[i] <= '0;
      end
    end else if (w_processing) begin
      r_pending[r_idx] <= '0;
      r_state[r_idx]   <= w_fire ? '0 : w_mem;
    end else if (w_accept) begin
      r_pending[in_idx] <= sat_add(r_pending[in_idx], in_current);
    end
  end

  // Sweep FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm       <= ST_IDLE;
      r_idx       <= '0;
      r_threshold <= SAT_W'(DEF_THRESHOLD);
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      spike_valid <= 1'b0;
      spike_idx   <= '0;
      mem_out     <= '0;
    end else begin
      spike_valid <= 1'b0;
      done        <= 1'b0;
      if (cfg_we) begin
        r_threshold <= cfg_threshold;
      end
      // A tick outside IDLE is dropped but remembered until reset.
      if (tick && (r_fsm != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (r_fsm)
        ST_IDLE: begin
          if (tick) begin
            r_fsm    <= ST_SWEEP;
            r_idx    <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        ST_SWEEP: begin
          spike_valid <= w_fire;
          spike_idx   <= r_idx;
          mem_out     <= w_mem;
          if (r_idx == LAST_IDX) begin
            r_fsm <= ST_DONE;
            done  <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        ST_DONE: begin
          r_fsm    <= ST_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          r_fsm    <= ST_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lif_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_scheduler
// Brief    : Self-checking bench for lif_scheduler. A reference model
//            predicts every sweep result when the tick is driven, and those
//            results are queued. Each scenario task pops the results and
//            compares them as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lif_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int RT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_idx = '0;
  logic [7:0]    in_current = '0;
  logic          cfg_we = 1'b0;
  logic [7:0]    cfg_threshold = '0;
  logic          in_ready, spike_valid, busy, done, overrun;
  logic [IW-1:0] spike_idx;
  logic [7:0]    mem_out;

  typedef struct {
    logic [IW-1:0] idx;
    logic [7:0]    mem;
    logic          spike;
    logic          chk_mem;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_state [N];
  int   m_pending [N];
  int   m_refr [N];
  int   m_thr;

  lif_scheduler #(
    .N_NEURONS     (N),
    .DEF_THRESHOLD (32),
    .REFRACT_TICKS (RT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_idx        (in_idx),
    .in_current    (in_current),
    .cfg_we        (cfg_we),
    .cfg_threshold (cfg_threshold),
    .spike_valid   (spike_valid),
    .spike_idx     (spike_idx),
    .mem_out       (mem_out),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_pending[i] = 0;
      m_refr[i] = 0;
    end
    m_thr = 32;
    sb.delete();
  endtask

  // Predict one full sweep and queue its results in processing order.
  task automatic model_sweep();
    exp_t e;
    int   nxt;
    for (int i = 0; i < N; i++) begin
      e.idx = IW'(i);
      nxt = m_pending[i] + (m_state[i] / 2);
      if (nxt > 255) nxt = 255;
`ifdef LIF_SCHED_REFRACTORY_EN
      if (m_refr[i] > 0) begin
        m_refr[i] = m_refr[i] - 1;
        m_state[i] = 0;
        m_pending[i] = 0;
        e.mem = 8'd0;
        e.spike = 1'b0;
        e.chk_mem = 1'b0;
        sb.push_back(e);
        continue;
      end
`endif
      e.mem = 8'(nxt);
      e.chk_mem = 1'b1;
      e.spike = (nxt >= m_thr);
      if (e.spike) begin
        m_state[i] = 0;
`ifdef LIF_SCHED_REFRACTORY_EN
        m_refr[i] = RT;
`endif
      end else begin
        m_state[i] = nxt;
      end
      m_pending[i] = 0;
      sb.push_back(e);
    end
  endtask

  task automatic stim(input int idx, input int cur);
    in_valid = 1'b1;
    in_idx = IW'(idx);
    in_current = 8'(cur);
    step();
    in_valid = 1'b0;
    m_pending[idx] = (m_pending[idx] + cur > 255) ? 255 : m_pending[idx] + cur;
  endtask

  task automatic start_tick();
    tick = 1'b1;
    model_sweep();
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    model_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (spike_valid !== 1'b0) begin failures++; $display("FAIL reset_spike_valid: got %b want 0", spike_valid); end
    start_tick();
    for (int k = 0; k < N; k++) begin
      step();
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL reset_sweep: scoreboard empty at cycle %0d", k); end
      else begin
        e = sb.pop_front();
        if (spike_valid !== e.spike || (e.spike && spike_idx !== e.idx) || (e.chk_mem && mem_out !== e.mem)) begin
          failures++;
          $display("FAIL reset_sweep n%0d: got v=%b i=%0d m=%0d want v=%b i=%0d m=%0d", k, spike_valid, spike_idx, mem_out, e.spike, e.idx, e.mem);
        end
      end
    end
    step();
  endtask

  task automatic test_single_spike();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) stim(1, 40);
      start_tick();
      for (int k = 0; k < N; k++) begin
        step();
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL single_spike: scoreboard empty at cycle %0d", k); end
        else begin
          e = sb.pop_front();
          if (spike_valid !== e.spike || (e.spike && spike_idx !== e.idx) || (e.chk_mem && mem_out !== e.mem)) begin
            failures++;
            $display("FAIL single_spike s%0d n%0d: got v=%b i=%0d m=%0d want v=%b i=%0d m=%0d", s, k, spike_valid, spike_idx, mem_out, e.spike, e.idx, e.mem);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_accumulate();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      stim(0, (s == 0) ? 20 : 10);
      start_tick();
      for (int k = 0; k < N; k++) begin
        step();
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL accumulate: scoreboard empty at cycle %0d", k); end
        else begin
          e = sb.pop_front();
          if (spike_valid !== e.spike || (e.spike && spike_idx !== e.idx) || (e.chk_mem && mem_out !== e.mem)) begin
            failures++;
            $display("FAIL accumulate s%0d n%0d: got v=%b i=%0d m=%0d want v=%b i=%0d m=%0d", s, k, spike_valid, spike_idx, mem_out, e.spike, e.idx, e.mem);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    stim(2, 200);
    stim(2, 100);
    start_tick();
    for (int k = 0; k < N; k++) begin
      step();
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL saturation: scoreboard empty at cycle %0d", k); end
      else begin
        e = sb.pop_front();
        if (spike_valid !== e.spike || (e.spike && spike_idx !== e.idx) || (e.chk_mem && mem_out !== e.mem)) begin
          failures++;
          $display("FAIL saturation n%0d: got v=%b i=%0d m=%0d want v=%b i=%0d m=%0d", k, spike_valid, spike_idx, mem_out, e.spike, e.idx, e.mem);
        end
      end
    end
    step();
  endtask

  task automatic test_overrun();
    exp_t e;
    int   dcount;
    int   dpos;
    dcount = 0;
    dpos = -1;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_initial: got %b want 0", overrun); end
    start_tick();
    for (int k = 0; k < N; k++) begin
      if (k == 1) tick = 1'b1;
      step();
      tick = 1'b0;
      if (done === 1'b1) begin dcount++; dpos = k; end
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL overrun_sweep: scoreboard empty at cycle %0d", k); end
      else begin
        e = sb.pop_front();
        if (spike_valid !== e.spike || (e.spike && spike_idx !== e.idx) || (e.chk_mem && mem_out !== e.mem)) begin
          failures++;
          $display("FAIL overrun_sweep n%0d: got v=%b i=%0d m=%0d want v=%b i=%0d m=%0d", k, spike_valid, spike_idx, mem_out, e.spike, e.idx, e.mem);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      if (done === 1'b1) dcount++;
    end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag: got %b want 1", overrun); end
    checks++; if (dcount != 1) begin failures++; $display("FAIL done_count: got %0d want 1", dcount); end
    checks++; if (dpos != N - 1) begin failures++; $display("FAIL done_position: got cycle %0d want %0d", dpos, N - 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL overrun_no_resweep busy: got %b want 0", busy); end
  endtask

  task automatic test_same_cycle_tick();
    exp_t e;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL same_cycle_in_ready: got %b want 1", in_ready); end
    tick = 1'b1;
    in_valid = 1'b1;
    in_idx = IW'(0);
    in_current = 8'd40;
    m_pending[0] = (m_pending[0] + 40 > 255) ? 255 : m_pending[0] + 40;
    model_sweep();
    step();
    tick = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      step();
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL same_cycle: scoreboard empty at cycle %0d", k); end
      else begin
        e = sb.pop_front();
        if (spike_valid !== e.spike || (e.spike && spike_idx !== e.idx) || (e.chk_mem && mem_out !== e.mem)) begin
          failures++;
          $display("FAIL same_cycle n%0d: got v=%b i=%0d m=%0d want v=%b i=%0d m=%0d", k, spike_valid, spike_idx, mem_out, e.spike, e.idx, e.mem);
        end
      end
    end
    step();
  endtask

  task automatic test_threshold();
    exp_t e;
    cfg_we = 1'b1;
    cfg_threshold = 8'd10;
    step();
    cfg_we = 1'b0;
    m_thr = 10;
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        stim(3, 12);
        stim(1, 10);
      end else begin
        stim(3, 50);
      end
      start_tick();
      for (int k = 0; k < N; k++) begin
        step();
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL threshold: scoreboard empty at cycle %0d", k); end
        else begin
          e = sb.pop_front();
          if (spike_valid !== e.spike || (e.spike && spike_idx !== e.idx) || (e.chk_mem && mem_out !== e.mem)) begin
            failures++;
            $display("FAIL threshold s%0d n%0d: got v=%b i=%0d m=%0d want v=%b i=%0d m=%0d", s, k, spike_valid, spike_idx, mem_out, e.spike, e.idx, e.mem);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_sweep();
    exp_t e;
    cfg_we = 1'b1;
    cfg_threshold = 8'd250;
    step();
    cfg_we = 1'b0;
    stim(0, 100);
    stim(1, 100);
    stim(2, 255);
    stim(3, 255);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < N + 4; k++) begin
      checks++;
      if (spike_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet c%0d: got spike_valid=%b busy=%b want 0 0", k, spike_valid, busy);
      end
      step();
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL abort_overrun: got %b want 0", overrun); end
    stim(0, 32);
    stim(1, 31);
    start_tick();
    for (int k = 0; k < N; k++) begin
      step();
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL post_reset: scoreboard empty at cycle %0d", k); end
      else begin
        e = sb.pop_front();
        if (spike_valid !== e.spike || (e.spike && spike_idx !== e.idx) || (e.chk_mem && mem_out !== e.mem)) begin
          failures++;
          $display("FAIL post_reset n%0d: got v=%b i=%0d m=%0d want v=%b i=%0d m=%0d", k, spike_valid, spike_idx, mem_out, e.spike, e.idx, e.mem);
        end
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_spike();
    test_accumulate();
    test_saturation();
    test_overrun();
    test_same_cycle_tick();
    test_threshold();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
